fpu_issue_queue: RTL and testbench

FPU_ISSUE_QUEUE -- requirements
Module: fpu_issue_queue

---
 rtl/fpu_issue_queue.sv | 157 +++++++++++++++
 tb/tb_fpu_issue_queue.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_queue.sv
// fpu_issue_queue: request FIFO in front of a single-outstanding FPU wrapper.
// A four-state FSM (IDLE/ISSUE/WAIT/HOLD) pops one request, pulses fpu_start,
// waits for fpu_done and holds the result until the consumer takes it.
// Optional WAIT watchdog: define FPU_ISSUE_TIMEOUT_EN.
module fpu_issue_queue #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [2:0]              req_op,
    input  logic [31:0]             req_a,
    input  logic [31:0]             req_b,
    output logic                    fpu_start,
    output logic [2:0]              fpu_op,
    output logic [31:0]             fpu_a,
    output logic [31:0]             fpu_b,
    input  logic                    fpu_done,
    input  logic [31:0]             fpu_result,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [31:0]             resp_data,
    output logic                    resp_err,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [31:0]  QNAN     = 32'h7FC00000;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    req_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    state_t        state, state_nxt;
    logic          push, pop, timeout;

    // Full check looks only at the registered count, so a same-cycle pop never frees a slot early.
    assign req_ready = (count < FULL_CNT);
    assign push      = req_valid && req_ready;

    // FIFO payload storage; contents need no reset because count gates visibility.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= '{op: req_op, a: req_a, b: req_b};
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next state plus the pop and start strobes; fpu_done only matters in WAIT.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        fpu_start = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                fpu_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (fpu_done || timeout) state_nxt = HOLD;
            end
            HOLD: begin
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch on pop (held through HOLD) and the response register.
    always_ff @(posedge clock) begin
        if (reset) begin
            fpu_op     <= '0;
            fpu_a      <= '0;
            fpu_b      <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else begin
            if (pop) begin
                fpu_op <= mem[rd_ptr].op;
                fpu_a  <= mem[rd_ptr].a;
                fpu_b  <= mem[rd_ptr].b;
            end
            if (state == WAIT && fpu_done) begin
                resp_data  <= fpu_result;
                resp_valid <= 1'b1;
            end else if (timeout) begin
                resp_data  <= QNAN;
                resp_valid <= 1'b1;
            end else if (state == HOLD && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

`ifdef FPU_ISSUE_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_cnt;

    // A real fpu_done in the last allowed cycle wins over the watchdog.
    assign timeout = (state == WAIT) && !fpu_done && (wd_cnt == WW'(TIMEOUT_CYCLES));

    // Watchdog reads 1 in the first WAIT cycle and is cleared outside WAIT.
    always_ff @(posedge clock) begin
        if (reset)               wd_cnt <= '0;
        else if (state == ISSUE) wd_cnt <= WW'(1);
        else if (state == WAIT)  wd_cnt <= wd_cnt + 1'b1;
        else                     wd_cnt <= '0;
    end

    // Error flag travels with the response: set by the watchdog, cleared by a real result.
    always_ff @(posedge clock) begin
        if (reset)                         resp_err <= 1'b0;
        else if (state == WAIT && fpu_done) resp_err <= 1'b0;
        else if (timeout)                  resp_err <= 1'b1;
    end
`else
    // Without the watchdog WAIT waits forever and TIMEOUT_CYCLES has no effect.
    localparam int UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
    assign timeout  = 1'b0;
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_issue_queue.sv
// tb_fpu_issue_queue: directed stimulus, a bench-side FPU stand-in, and a
// queue-based reference model compared against the DUT every cycle.
module tb_fpu_issue_queue;
    localparam int DEPTH = 4;
    localparam int TO    = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef FPU_ISSUE_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_op = '0;
    logic [31:0]   req_a = '0, req_b = '0;
    logic          fpu_start;
    logic [2:0]    fpu_op;
    logic [31:0]   fpu_a, fpu_b;
    logic          fpu_done;
    logic [31:0]   fpu_result;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [31:0]   resp_data;
    logic          resp_err;
    logic [CW-1:0] count;

    fpu_issue_queue #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_done(fpu_done), .fpu_result(fpu_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .count(count)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endfunction

    // Stand-in FPU arithmetic: 1.0 + 2.0 = 3.0 for the pinned case, a simple mix otherwise.
    function automatic logic [31:0] fpu_fn(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        if (op == 3'd0 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        return a + b + {29'd0, op};
    endfunction

    // ---------------- FPU stand-in: answers fpu_lat cycles after fpu_start
    logic        fpu_auto = 1'b1;
    int          fpu_lat = 3;
    int          fpu_timer = 0;
    logic        done_auto = 1'b0, done_force = 1'b0;
    logic [31:0] res_auto = '0, res_force = '0;
    logic        rst_s;

    assign fpu_done   = done_auto | done_force;
    assign fpu_result = done_force ? res_force : res_auto;

    initial forever begin
        @(posedge clock);
        rst_s = reset;
        #1;
        done_auto = 1'b0;
        if (rst_s) fpu_timer = 0;
        else begin
            if (fpu_timer > 0) begin
                fpu_timer--;
                if (fpu_timer == 0) done_auto = 1'b1;
            end
            if (fpu_start && fpu_auto) begin
                fpu_timer = fpu_lat;
                res_auto  = fpu_fn(fpu_op, fpu_a, fpu_b);
            end
        end
    end

    // ---------------- reference model, checked on every falling edge
    req_t        m_q[$];
    req_t        m_cur;
    int          m_phase;   // 0 idle, 1 issuing, 2 waiting on FPU, 3 holding result
    logic        m_rv, m_re;
    logic [31:0] m_rd;
    int          m_wc;
    logic        sb_on = 1'b0;

    initial begin
        m_cur = '0; m_phase = 0; m_rv = 1'b0; m_re = 1'b0; m_rd = '0; m_wc = 0;
        forever begin
            bit push;
            @(negedge clock);
            if (sb_on) begin
                chk("sb_count",      32'(count),      32'(m_q.size()));
                chk("sb_req_ready",  32'(req_ready),  32'(m_q.size() < DEPTH));
                chk("sb_fpu_start",  32'(fpu_start),  32'(m_phase == 1));
                chk("sb_resp_valid", 32'(resp_valid), 32'(m_rv));
                if (m_phase != 0) begin
                    chk("sb_fpu_op", 32'(fpu_op), 32'(m_cur.op));
                    chk("sb_fpu_a",  fpu_a,       m_cur.a);
                    chk("sb_fpu_b",  fpu_b,       m_cur.b);
                end
                if (m_rv) begin
                    chk("sb_resp_data", resp_data,        m_rd);
                    chk("sb_resp_err",  32'(resp_err),    32'(m_re));
                end
            end
            // Inputs are stable until the next edge, so advance the model to it now.
            if (reset) begin
                m_q.delete();
                m_cur = '0; m_phase = 0; m_rv = 1'b0; m_re = 1'b0; m_rd = '0; m_wc = 0;
            end else begin
                push = req_valid && (m_q.size() < DEPTH);
                case (m_phase)
                    0: if (m_q.size() > 0) begin m_cur = m_q.pop_front(); m_phase = 1; end
                    1: begin m_phase = 2; m_wc = 0; end
                    2: begin
                        m_wc++;
                        if (fpu_done) begin
                            m_rd = fpu_result; m_rv = 1'b1; m_re = 1'b0; m_phase = 3;
                        end else if (TMO_EN && m_wc == TO) begin
                            m_rd = 32'h7FC00000; m_rv = 1'b1; m_re = 1'b1; m_phase = 3;
                        end
                    end
                    3: if (resp_ready) begin m_rv = 1'b0; m_phase = 0; end
                    default: ;
                endcase
                if (push) m_q.push_back('{op: req_op, a: req_a, b: req_b});
            end
        end
    end

    // ---------------- stimulus
    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    endtask

    initial begin
        int          k, s_cyc, rv_cyc, starts;
        logic        acc, seen_rv, seen_st;
        logic [31:0] got[$];
        req_t        reqs[3];

        // reset state
        reset = 1'b1;
        tick();
        sb_on = 1'b1;
        tick();
        chk("rst_count",      32'(count),      32'd0);
        chk("rst_req_ready",  32'(req_ready),  32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_fpu_start",  32'(fpu_start),  32'd0);
        chk("rst_resp_data",  resp_data,       32'd0);
        chk("rst_resp_err",   32'(resp_err),   32'd0);
        chk("rst_fpu_a",      fpu_a,           32'd0);
        reset = 1'b0;
        tick();

        // single op 1.0 + 2.0, FPU answers 3 cycles after start
        fpu_auto = 1'b1; fpu_lat = 3;
        k = cyc;
        drive(3'd0, 32'h3F800000, 32'h40000000);
        tick();
        req_valid = 1'b0;
        starts = 0; s_cyc = -1; rv_cyc = -1;
        for (int i = 0; i < 20 && rv_cyc < 0; i++) begin
            if (fpu_start) begin starts++; s_cyc = cyc; end
            if (resp_valid) rv_cyc = cyc;
            else tick();
        end
        chk("t1_start_latency", 32'(s_cyc - k),      32'd2);
        chk("t1_resp_latency",  32'(rv_cyc - s_cyc), 32'd4);
        chk("t1_start_pulses",  32'(starts),         32'd1);
        chk("t1_resp_data",     resp_data,           32'h40400000);
        chk("t1_resp_err",      32'(resp_err),       32'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("t1_resp_taken", 32'(resp_valid), 32'd0);

        // stall in HOLD, then five back-to-back requests into a 4-deep FIFO
        drive(3'd1, 32'h10, 32'h20);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 30 && !resp_valid; i++) tick();
        chk("t2_hold_reached", 32'(resp_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            drive(3'd2, 32'h100 + 32'(i), 32'h200);
            tick();
        end
        chk("t2_count_full", 32'(count),     32'd4);
        chk("t2_not_ready",  32'(req_ready), 32'd0);
        drive(3'd3, 32'h555, 32'h666);
        repeat (3) tick();
        chk("t2_fifth_blocked", 32'(count), 32'd4);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) begin
            if (req_ready) acc = 1'b1;
            tick();
        end
        req_valid = 1'b0;
        chk("t2_fifth_accepted", 32'(acc),   32'd1);
        chk("t2_count_after",    32'(count), 32'd4);
        resp_ready = 1'b1;
        repeat (60) tick();
        resp_ready = 1'b0;
        chk("t2_drained", 32'(count), 32'd0);

        // result held 10 cycles with a stray fpu_done, then in-order responses
        reqs[0] = '{op: 3'd4, a: 32'h1000, b: 32'h0001};
        reqs[1] = '{op: 3'd5, a: 32'h2000, b: 32'h0002};
        reqs[2] = '{op: 3'd6, a: 32'h3000, b: 32'h0003};
        for (int i = 0; i < 3; i++) begin
            drive(reqs[i].op, reqs[i].a, reqs[i].b);
            tick();
        end
        req_valid = 1'b0;
        for (int i = 0; i < 30 && !resp_valid; i++) tick();
        chk("t3_first_result", 32'(resp_valid), 32'd1);
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            chk("t3_hold_data", resp_data, fpu_fn(reqs[0].op, reqs[0].a, reqs[0].b));
            if (fpu_start) starts++;
            done_force = (i == 4);
            res_force  = 32'hDEADBEEF;
            tick();
        end
        done_force = 1'b0;
        chk("t3_no_restart", 32'(starts), 32'd0);
        resp_ready = 1'b1;
        got.delete();
        for (int i = 0; i < 60 && got.size() < 3; i++) begin
            if (resp_valid) got.push_back(resp_data);
            tick();
        end
        resp_ready = 1'b0;
        chk("t3_resp_count", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            if (i < got.size())
                chk("t3_resp_order", got[i], fpu_fn(reqs[i].op, reqs[i].a, reqs[i].b));

        // reset mid-WAIT with two entries queued; late fpu_done must be ignored
        fpu_auto = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(3'd7, 32'h40 + 32'(i), 32'h1);
            tick();
        end
        req_valid = 1'b0;
        chk("t4_queued", 32'(count), 32'd2);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t4_count",      32'(count),      32'd0);
        chk("t4_resp_valid", 32'(resp_valid), 32'd0);
        chk("t4_req_ready",  32'(req_ready),  32'd1);
        chk("t4_fpu_a",      fpu_a,           32'd0);
        tick();
        done_force = 1'b1; res_force = 32'h12345678;
        tick();
        done_force = 1'b0;
        seen_rv = 1'b0; seen_st = 1'b0;
        repeat (10) begin
            if (resp_valid) seen_rv = 1'b1;
            if (fpu_start)  seen_st = 1'b1;
            tick();
        end
        chk("t4_no_late_resp", 32'(seen_rv), 32'd0);
        chk("t4_no_start",     32'(seen_st), 32'd0);

`ifdef FPU_ISSUE_TIMEOUT_EN
        // watchdog: no fpu_done, response after the 16th WAIT cycle
        drive(3'd1, 32'hAAAA, 32'h5555);
        tick();
        req_valid = 1'b0;
        s_cyc = -1; rv_cyc = -1;
        for (int i = 0; i < 40 && rv_cyc < 0; i++) begin
            if (fpu_start) s_cyc = cyc;
            if (resp_valid) rv_cyc = cyc;
            else tick();
        end
        chk("t5_timeout_latency", 32'(rv_cyc - s_cyc), 32'(TO + 1));
        chk("t5_timeout_err",     32'(resp_err),       32'd1);
        chk("t5_timeout_data",    resp_data,           32'h7FC00000);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("t5_taken", 32'(resp_valid), 32'd0);
`else
        // no watchdog: WAIT never gives up
        drive(3'd1, 32'hAAAA, 32'h5555);
        tick();
        req_valid = 1'b0;
        seen_rv = 1'b0;
        repeat (100) begin
            if (resp_valid) seen_rv = 1'b1;
            tick();
        end
        chk("t5_waits_forever", 32'(seen_rv),  32'd0);
        chk("t5_err_tied",      32'(resp_err), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
`endif
        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got %0d cycles", cyc);
        $fatal(1, "bench time limit");
    end

endmodule
